// File: rtl/coarse_delay_line_pkg.sv
// Shared types for the coarse delay line.
// Holds the fill/run state encoding.
package coarse_delay_line_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/coarse_delay_line_if.sv
// Sample stream bundle: data, data_valid and ce.
// The master drives the stream and the slave consumes it.
interface coarse_delay_line_if #(
    parameter int WIDTH = 14
);
    logic             data_valid;
    logic             ce;
    logic [WIDTH-1:0] data;

    modport master (output data_valid, ce, data);
    modport slave  (input  data_valid, ce, data);
endinterface

// File: rtl/coarse_delay_line_sdp_ram.sv
// Simple dual-port RAM with a read-first, one-cycle synchronous read.
// The memory array has no reset, so it maps onto block RAM.
module sdp_ram #(
    parameter int WIDTH  = 14,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/coarse_delay_line.sv
// Programmable sample-count delay built on a circular block-RAM buffer.
// Preserves the data_valid/ce framing of the incoming stream.
module coarse_delay_line
    import coarse_delay_line_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] delay_i,
    coarse_delay_line_if.slave  s_in,
    coarse_delay_line_if.master m_out
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_fill_cnt;
    logic [ADDR_W-1:0] r_delay_q;
    logic              r_dv;
    logic              r_ce;
    logic              r_use_ram;
    logic [WIDTH-1:0]  r_data;

    logic              w_acc;
    logic              w_chg;
    logic              w_run;
    logic [ADDR_W-1:0] w_cnt;
    logic [ADDR_W-1:0] w_cnt_inc;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [WIDTH-1:0]  w_rd_data;

    assign w_acc = s_in.data_valid;

    // The delay captured on this sample already applies to it.
    assign w_rd_addr = r_wr_ptr - delay_i;

    sdp_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .i_we    (w_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (s_in.data),
        .i_re    (w_acc),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_fill_cnt;
        w_chg       = (delay_i != r_delay_q);
        w_cnt       = w_chg ? '0 : r_fill_cnt;
        w_cnt_inc   = (&w_cnt) ? w_cnt : w_cnt + ADDR_W'(1);
        w_run       = 1'b0;
        unique case (r_state)
            RUN:  w_run = !w_chg || (w_cnt >= delay_i);
            FILL: w_run = (w_cnt >= delay_i);
            default: w_run = 1'b0;
        endcase
        if (w_acc) begin
            if (w_run) begin
                w_state_nxt = RUN;
                w_cnt_nxt   = w_cnt;
            end else begin
                w_cnt_nxt   = w_cnt_inc;
                w_state_nxt = (w_cnt_inc >= delay_i) ? RUN : FILL;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= FILL;
            r_fill_cnt <= '0;
            r_wr_ptr   <= '0;
            r_delay_q  <= '0;
            r_dv       <= 1'b0;
            r_ce       <= 1'b0;
            r_use_ram  <= 1'b0;
            r_data     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_cnt_nxt;
            r_dv       <= w_acc;
            r_ce       <= s_in.ce;
            if (w_acc) begin
                r_wr_ptr  <= r_wr_ptr + ADDR_W'(1);
                r_delay_q <= delay_i;
                r_use_ram <= w_run && (delay_i != '0);
                r_data    <= (delay_i == '0) ? s_in.data : '0;
            end
        end
    end

    assign m_out.data_valid = r_dv;
    assign m_out.ce         = r_ce;
    assign m_out.data       = r_use_ram ? w_rd_data : r_data;

endmodule

// File: tb/tb_coarse_delay_line.sv
// Directed bench for coarse_delay_line with a history-based reference model.
// Checks every cycle and pins the model with literal sequences.
module tb_coarse_delay_line;

    localparam int W = 14;
    localparam int A = 4;

    logic         clk_i  = 1'b1;
    logic         rst_ni = 1'b0;
    logic [A-1:0] delay_i = '0;

    coarse_delay_line_if #(.WIDTH(W)) s_in ();
    coarse_delay_line_if #(.WIDTH(W)) m_out ();

    coarse_delay_line #(
        .WIDTH  (W),
        .ADDR_W (A)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .delay_i (delay_i),
        .s_in    (s_in),
        .m_out   (m_out)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Random ce on every cycle; only ce_o may follow it without a sample.
    always @(negedge clk_i) s_in.ce = 1'($urandom_range(0, 1));

    // Model: output equals the input dq samples back once dq samples
    // have arrived since the last delay change or reset, else zero.
    int hist[$];
    int k      = 0;
    int dq     = 0;
    int e_data = 0;
    int in_cnt = 0;
    int out_cnt = 0;

    always @(posedge clk_i) begin
        logic v, c;
        int   d, dl, n;
        v  = s_in.data_valid;
        c  = s_in.ce;
        d  = int'(s_in.data);
        dl = int'(delay_i);
        if (!rst_ni) begin
            hist.delete();
            k      = 0;
            dq     = 0;
            e_data = 0;
        end else if (v) begin
            if (dl != dq) k = 0;
            dq = dl;
            hist.push_back(d);
            n = hist.size() - 1;
            e_data = (k >= dq) ? hist[n-dq] : 0;
            k++;
            in_cnt++;
        end
        #1;
        chk("valid_o", int'(m_out.data_valid), int'(rst_ni && v));
        chk("ce_o", int'(m_out.ce), int'(rst_ni && c));
        chk("data_o", int'(m_out.data), e_data);
        if (m_out.data_valid) out_cnt++;
    end

    task automatic send(input int val, input int gap, output int got);
        @(negedge clk_i);
        s_in.data_valid = 1'b1;
        s_in.data       = val[W-1:0];
        @(negedge clk_i);
        s_in.data_valid = 1'b0;
        got = int'(m_out.data);
        repeat (gap - 2) @(negedge clk_i);
    endtask

    initial begin
        int g;
        s_in.data_valid = 1'b0;
        s_in.data       = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_data", int'(m_out.data), 0);
        chk("rst_valid", int'(m_out.data_valid), 0);
        chk("rst_ce", int'(m_out.ce), 0);
        rst_ni = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            send(i, 4, g);
            chk("bypass", g, i);
        end

        delay_i = 4'd3;
        for (int i = 0; i < 9; i++) begin
            send(10 + i, 3, g);
            chk("delay3", g, (i < 3) ? 0 : 10 + i - 3);
        end

        delay_i = 4'd15;
        for (int i = 0; i < 40; i++) begin
            send(100 + i, 2, g);
            chk("delay15", g, (i < 15) ? 0 : 100 + i - 15);
        end

        delay_i = 4'd3;
        for (int i = 0; i < 8; i++) send(200 + i, 3, g);
        chk("pre_change", g, 204);
        delay_i = 4'd5;
        for (int i = 0; i < 10; i++) begin
            send(300 + i, 3, g);
            chk("delay5", g, (i < 5) ? 0 : 300 + i - 5);
        end

        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_data", int'(m_out.data), 0);
        chk("mid_rst_valid", int'(m_out.data_valid), 0);
        chk("mid_rst_ce", int'(m_out.ce), 0);
        repeat (2) @(negedge clk_i);
        rst_ni  = 1'b1;
        delay_i = 4'd2;
        for (int i = 0; i < 6; i++) begin
            send(500 + i, 3, g);
            chk("after_rst", g, (i < 2) ? 0 : 500 + i - 2);
        end

        delay_i = 4'd1;
        for (int i = 0; i < 20; i++) begin
            send(600 + i, 2, g);
            chk("dense", g, (i < 1) ? 0 : 600 + i - 1);
        end

        repeat (4) @(negedge clk_i);
        chk("pulse_count", out_cnt, in_cnt);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/coarse_delay_line.md
Name: coarse_delay_line

Overview:
- Programmable sample-count delay that sits directly downstream of the fine delay chain in the pt_feedback path.
- Consumes the data/data_valid/ce stream produced by the last fine delay stage.
- Delays each valid sample by delay_i valid samples (0..2^ADDR_W-1) using a circular buffer in block RAM.
- Re-emits the samples with the same data_valid/ce framing, so the next stage (feedback gain/output) sees an unchanged protocol.

Parameters:
- WIDTH, 14, sample width in bits (two's complement, not interpreted).
- ADDR_W, 10, buffer address width; maximum delay is 2^ADDR_W-1 samples.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- data_valid_i  input  1  qualifies data_i; single-cycle pulses, never held high continuously.
- ce_i  input  1  timekeeping clock enable from the upstream stage.
- delay_i  input  ADDR_W  requested delay in valid samples; quasi-static control register.
- data_i  input  WIDTH  input sample.
- data_valid_o  output  1  qualifies data_o.
- ce_o  output  1  ce_i delayed by one clk, aligned with data_valid_o.
- data_o  output  WIDTH  delayed sample.

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i. On reset, data_o=0, data_valid_o=0, ce_o=0, wr_ptr=0, fill_cnt=0, delay_q=0, state=FILL. RAM contents are not reset.
- Accepted sample: data_valid_i high at a clk_i edge; this is independent of ce_i.
- Per accepted sample:
  - write data_i at wr_ptr;
  - issue a synchronous read at rd_addr = wr_ptr - delay_q (mod 2^ADDR_W);
  - increment wr_ptr, wrapping at 2^ADDR_W.
- Latency: data_valid_o pulses exactly 1 clk after each accepted sample. data_o updates on that same edge and holds between pulses.
- ce_o: ce_i registered once, unconditionally, so it stays aligned with data_valid_o exactly as it left the upstream stage.
- delay_q capture: delay_q is loaded from delay_i only on an accepted sample. The new value applies to that sample.
- Delay change: if delay_i != delay_q on an accepted sample, clear fill_cnt to 0 and go to state FILL in the same cycle. The current sample is the first counted write.
- State FILL:
  - data_o = 0 on each output pulse;
  - fill_cnt increments per accepted sample;
  - move to RUN when fill_cnt reaches delay_q, i.e. the sample whose delayed partner has already been written.
- State RUN:
  - data_o = RAM read data;
  - fill_cnt is frozen.
- delay_q=0: bypass. data_o = data_i of the same accepted sample, registered, with 1 clk latency. The RAM read is ignored. Go directly to RUN.
- delay_q=2^ADDR_W-1: read address equals wr_ptr+1, the oldest entry. No read/write address collision can occur because a delay of 2^ADDR_W is unrepresentable.
- Wrap-around: pointer arithmetic is unsigned ADDR_W bits with natural wrap; no special case.
- fill_cnt: width ADDR_W; saturates and never wraps.
- Back-to-back valid pulses (e.g. a one-clk gap): fully supported, one output per input, no drops.
- Reset mid-operation: outputs go to 0 immediately (asynchronous). After release, behaviour is as from power-up, including a full FILL.
- ce_i without data_valid_i: only ce_o responds; the buffer is untouched.

Decomposition:
- No shared package is required; ADDR_W and WIDTH are local parameters.
- One sub-module: sdp_ram.
  - Simple dual-port RAM, one write port and one read port, same clock.
  - Read-first, 1-cycle synchronous read, parameterised WIDTH/ADDR_W.
  - Written so Vivado infers BRAM; no reset on the memory array.
- FSM (FILL/RUN), pointers, fill counter and output mux live in coarse_delay_line.

Test Plan:
- Reset/bypass: with delay_i=0, feed valid pulses every 4 clk with data 1,2,3 -> data_valid_o 1 clk after each, data_o=1,2,3; ce_o mirrors ce_i shifted by 1 clk.
- Fixed delay: with delay_i=3, feed ramp 10,11,12,... -> outputs 0,0,0,10,11,12,...; exactly one data_valid_o per input.
- Max delay/wrap: with ADDR_W=4 and delay_i=15, feed 40 ramp samples starting at 100 -> output k (k>=15) equals 100+k-15, with correct values across the pointer wrap at sample 16.
- Delay change: run at delay 3, then switch delay_i to 5 -> next 5 outputs are 0, then the output equals the input from 5 samples earlier.
- Reset mid-stream: assert rst_ni low between valid pulses while in RUN -> data_o, data_valid_o and ce_o are 0 immediately. After release with delay 2, the first 2 outputs are 0.
- Dense input: valid pulses every 2 clk at delay 1, with ce_i random -> no missing or duplicated outputs, and ce_o equals ce_i delayed by 1 clk.
